// File: rtl/dac_update_scheduler.sv
// Shares one DAC serializer across NUM_CH channels: latches the latest word per channel and, on
// each frame tick, dispatches every pending enabled channel once in round-robin order.
module dac_update_scheduler #(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       dataclk_i,
  input  logic                       reset_ni,
  input  logic                       frame_start_i,
  input  logic [NUM_CH-1:0]          ch_en_i,
  input  logic [NUM_CH-1:0]          upd_req_i,
  input  logic [NUM_CH*DATA_W-1:0]   upd_data_i,
  input  logic                       ser_busy_i,
  input  logic                       ser_done_i,
  input  logic                       err_clr_i,
  output logic                       ser_start_o,
  output logic [$clog2(NUM_CH)-1:0]  ser_ch_o,
  output logic [DATA_W-1:0]          ser_data_o,
  output logic [NUM_CH-1:0]          pending_o,
  output logic                       frame_active_o,
  output logic                       overrun_o,
  output logic                       timeout_err_o
);

  localparam int unsigned ChW  = $clog2(NUM_CH);
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Last WAIT cycle before abandoning: the flag then shows TIMEOUT cycles after ser_start.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 2);

  typedef enum logic [1:0] {StIdle, StScan, StIssue, StWait} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   shadow_q [NUM_CH];
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [NUM_CH-1:0]   snap_q;
  logic [ChW-1:0]      last_q, sel_q;
  logic [CntW-1:0]     cnt_q;
  logic                frame_active_q, overrun_q, timeout_err_q;

  logic [NUM_CH-1:0]   snap_live;
  logic [NUM_CH-1:0]   sel_oh;
  logic                found;
  logic [ChW-1:0]      pick;
  logic                issue_fire;

  // Rotating priority search starting just after the last served channel.
  always_comb begin
    snap_live = snap_q & ch_en_i;
    found     = 1'b0;
    pick      = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      if (!found && snap_live[last_q + ChW'(k)]) begin
        found = 1'b1;
        pick  = last_q + ChW'(k);
      end
    end
  end

  assign sel_oh = NUM_CH'(1) << sel_q;

  // A channel disabled while waiting in ISSUE is dropped rather than sent.
  assign issue_fire = (state_q == StIssue) && !ser_busy_i && ch_en_i[sel_q];

  always_comb begin
    pending_d = pending_q;
    if (issue_fire) pending_d = pending_d & ~sel_oh;
    pending_d = (pending_d | upd_req_i) & ch_en_i;
  end

  always_ff @(posedge dataclk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= StIdle;
      pending_q      <= '0;
      snap_q         <= '0;
      last_q         <= ChW'(NUM_CH - 1);
      sel_q          <= '0;
      cnt_q          <= '0;
      frame_active_q <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (upd_req_i[i] && ch_en_i[i]) shadow_q[i] <= upd_data_i[i*DATA_W +: DATA_W];
      end
      overrun_q     <= (frame_start_i && frame_active_q) || (overrun_q && !err_clr_i);
      timeout_err_q <= timeout_err_q && !err_clr_i;
      snap_q        <= snap_q & ch_en_i;

      unique case (state_q)
        StIdle: begin
          if (frame_start_i) begin
            snap_q         <= pending_q & ch_en_i;
            frame_active_q <= 1'b1;
            state_q        <= StScan;
          end
        end
        StScan: begin
          if (found) begin
            sel_q   <= pick;
            state_q <= StIssue;
          end else begin
            frame_active_q <= 1'b0;
            state_q        <= StIdle;
          end
        end
        StIssue: begin
          if (!ch_en_i[sel_q]) begin
            state_q <= StScan;
          end else if (!ser_busy_i) begin
            snap_q  <= snap_q & ch_en_i & ~sel_oh;
            last_q  <= sel_q;
            cnt_q   <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (ser_done_i) begin
            state_q <= StScan;
          end else if (cnt_q == CntLast) begin
            timeout_err_q <= 1'b1;
            state_q       <= StScan;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ser_start_o    = issue_fire;
  assign ser_ch_o       = issue_fire ? sel_q : '0;
  assign ser_data_o     = issue_fire ? shadow_q[sel_q] : '0;
  assign pending_o      = pending_q;
  assign frame_active_o = frame_active_q;
  assign overrun_o      = overrun_q;
  assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Bench for dac_update_scheduler: directed scenarios plus randomized traffic, all checked against
// an event-level reference model of frames, channel picks and serializer handshakes.
module tb_dac_update_scheduler;

  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 64;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     frame_start = 1'b0;
  logic [NUM_CH-1:0]        ch_en = '0;
  logic [NUM_CH-1:0]        upd_req = '0;
  logic [NUM_CH*DATA_W-1:0] upd_data = '0;
  logic                     ser_busy = 1'b0;
  logic                     ser_done = 1'b0;
  logic                     err_clr = 1'b0;
  logic                     ser_start;
  logic [2:0]               ser_ch;
  logic [DATA_W-1:0]        ser_data;
  logic [NUM_CH-1:0]        pending;
  logic                     frame_active, overrun, timeout_err;

  dac_update_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .dataclk_i      (clk),
    .reset_ni       (rst_n),
    .frame_start_i  (frame_start),
    .ch_en_i        (ch_en),
    .upd_req_i      (upd_req),
    .upd_data_i     (upd_data),
    .ser_busy_i     (ser_busy),
    .ser_done_i     (ser_done),
    .err_clr_i      (err_clr),
    .ser_start_o    (ser_start),
    .ser_ch_o       (ser_ch),
    .ser_data_o     (ser_data),
    .pending_o      (pending),
    .frame_active_o (frame_active),
    .overrun_o      (overrun),
    .timeout_err_o  (timeout_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int          cyc      = 0;

  // Serializer environment
  int ser_cnt    = 0;
  bit ser_auto   = 1'b1;
  bit force_busy = 1'b0;

  // Observed dispatches
  int          log_ch   [$];
  int          log_data [$];
  int          log_cyc  [$];

  // Reference model
  logic [DATA_W-1:0] m_shadow [NUM_CH];
  logic [NUM_CH-1:0] m_pend, m_snap;
  int                m_last, m_issue, m_start;
  bit                m_active, m_scan, m_wait, m_ovr, m_tmo;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_CH-1:0] s, input int last);
    int res = -1;
    for (int k = 1; k <= int'(NUM_CH); k++) begin
      int idx = (last + k) % NUM_CH;
      if (res < 0 && s[idx]) res = idx;
    end
    return res;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(NUM_CH); i++) m_shadow[i] = '0;
    m_pend = '0; m_snap = '0; m_last = NUM_CH - 1; m_issue = -1; m_start = 0;
    m_active = 0; m_scan = 0; m_wait = 0; m_ovr = 0; m_tmo = 0;
  endtask

  // One clock cycle: check, predict, clock, commit. Inputs are set by the caller beforehand.
  task automatic step();
    bit                exp_start = 0;
    int                exp_ch = 0;
    logic [DATA_W-1:0] exp_data = '0;
    int                issued = -1;
    int                pk;
    logic [NUM_CH-1:0] snap_n = m_snap;
    logic [NUM_CH-1:0] pend_n;
    int                last_n = m_last, issue_n = m_issue, start_n = m_start;
    bit                active_n = m_active, scan_n = 0, wait_n = m_wait, tmo_set = 0;
    #1;
    check_eq("pending", pending, m_pend);
    check_eq("frame_active", frame_active, m_active);
    check_eq("overrun", overrun, m_ovr);
    check_eq("timeout_err", timeout_err, m_tmo);

    if (m_issue >= 0) begin
      if (!ch_en[m_issue]) begin
        issue_n = -1; scan_n = 1;
      end else if (!ser_busy) begin
        exp_start = 1; exp_ch = m_issue; exp_data = m_shadow[m_issue]; issued = m_issue;
        snap_n[m_issue] = 1'b0; last_n = m_issue; issue_n = -1; wait_n = 1; start_n = cyc;
      end
    end else if (m_wait) begin
      if (ser_done) begin
        wait_n = 0; scan_n = 1;
      end else if (cyc - m_start == int'(TIMEOUT) - 1) begin
        tmo_set = 1; wait_n = 0; scan_n = 1;
      end
    end else if (m_scan) begin
      pk = rr_pick(m_snap & ch_en, m_last);
      if (pk < 0) active_n = 0;
      else issue_n = pk;
    end
    if (!m_active && frame_start) begin
      snap_n = m_pend & ch_en; active_n = 1; scan_n = 1;
    end
    snap_n = snap_n & ch_en;

    check_eq("ser_start", ser_start, exp_start);
    if (exp_start) begin
      check_eq("ser_ch", ser_ch, exp_ch);
      check_eq("ser_data", ser_data, exp_data);
    end
    if (ser_start) begin
      log_ch.push_back(int'(ser_ch)); log_data.push_back(int'(ser_data)); log_cyc.push_back(cyc);
      if (ser_auto) ser_cnt = 10;
    end

    pend_n = m_pend;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (issued == i) pend_n[i] = 1'b0;
      if (upd_req[i]) pend_n[i] = 1'b1;
      if (!ch_en[i]) pend_n[i] = 1'b0;
    end
    m_ovr = (frame_start && m_active) || (m_ovr && !err_clr);
    m_tmo = tmo_set || (m_tmo && !err_clr);
    for (int i = 0; i < int'(NUM_CH); i++)
      if (upd_req[i] && ch_en[i]) m_shadow[i] = upd_data[i*DATA_W +: DATA_W];

    @(posedge clk);
    #1;
    cyc++;
    m_pend = pend_n; m_snap = snap_n; m_last = last_n; m_issue = issue_n; m_start = start_n;
    m_active = active_n; m_scan = scan_n; m_wait = wait_n;

    ser_done = 1'b0;
    if (ser_cnt > 0) begin
      ser_cnt--;
      if (ser_cnt == 0) ser_done = 1'b1;
    end
    ser_busy = force_busy || (ser_cnt > 0);
    frame_start = 1'b0; upd_req = '0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame_start = 0; upd_req = '0; err_clr = 0; ser_done = 0; ser_busy = 0;
    ser_cnt = 0; force_busy = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic write_ch(input int ch, input logic [DATA_W-1:0] d);
    upd_req[ch] = 1'b1;
    upd_data[ch*DATA_W +: DATA_W] = d;
    step();
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while (m_active && n < budget) begin step(); n++; end
    step();
    check_eq(tag, frame_active, 1'b0);
  endtask

  task automatic wait_log(input int cnt, input int budget);
    int n = 0;
    while (log_ch.size() < cnt && n < budget) begin step(); n++; end
    check_eq("issue_seen", log_ch.size() >= cnt, 1'b1);
  endtask

  task automatic clear_log();
    log_ch.delete(); log_data.delete(); log_cyc.delete();
  endtask

  initial begin
    int t0, n0, k;
    do_reset();

    // Round-robin order from reset
    ch_en = 8'h07;
    upd_req = 8'h07;
    upd_data[0*DATA_W +: DATA_W] = 16'h1111;
    upd_data[1*DATA_W +: DATA_W] = 16'h2222;
    upd_data[2*DATA_W +: DATA_W] = 16'h3333;
    step();
    clear_log();
    frame_start = 1; step();
    run_idle("rr_frame_end", 200);
    check_eq("rr_count", log_ch.size(), 3);
    check_eq("rr_ch0", log_ch[0], 0); check_eq("rr_d0", log_data[0], 16'h1111);
    check_eq("rr_ch1", log_ch[1], 1); check_eq("rr_d1", log_data[1], 16'h2222);
    check_eq("rr_ch2", log_ch[2], 2); check_eq("rr_d2", log_data[2], 16'h3333);
    check_eq("rr_pending", pending, 8'h00);

    // Fairness: serve ch1 alone so the pointer rests at 1, then ch0 and ch2 compete
    write_ch(1, 16'h5555);
    frame_start = 1; step();
    run_idle("fair_pre_end", 200);
    write_ch(2, 16'h0AAA); write_ch(2, 16'h0BBB); write_ch(2, 16'h0CCC);
    write_ch(0, 16'h1111);
    clear_log();
    frame_start = 1; step();
    run_idle("fair_end", 200);
    check_eq("fair_count", log_ch.size(), 2);
    check_eq("fair_first_ch", log_ch[0], 2); check_eq("fair_coalesced", log_data[0], 16'h0CCC);
    check_eq("fair_second_ch", log_ch[1], 0); check_eq("fair_second_d", log_data[1], 16'h1111);

    // Same-cycle request on the channel being issued
    write_ch(0, 16'h1111);
    clear_log();
    frame_start = 1; step();
    step();
    write_ch(0, 16'h7777);
    run_idle("same_end", 200);
    check_eq("same_old_sent", log_data[0], 16'h1111);
    check_eq("same_pending", pending[0], 1'b1);
    clear_log();
    frame_start = 1; step();
    run_idle("same_next_end", 200);
    check_eq("same_new_ch", log_ch[0], 0);
    check_eq("same_new_sent", log_data[0], 16'h7777);

    // Overrun during WAIT and mid-frame disable of ch2
    upd_req = 8'h06;
    upd_data[1*DATA_W +: DATA_W] = 16'h2111;
    upd_data[2*DATA_W +: DATA_W] = 16'h2222;
    step();
    clear_log();
    frame_start = 1; step();
    wait_log(1, 20);
    repeat (3) step();
    frame_start = 1; ch_en = 8'h03; step();
    check_eq("ovr_set", overrun, 1'b1);
    run_idle("ovr_end", 200);
    check_eq("dis_count", log_ch.size(), 1);
    check_eq("dis_ch", log_ch[0], 1);
    check_eq("dis_pending2", pending[2], 1'b0);
    err_clr = 1; step();
    check_eq("ovr_clr", overrun, 1'b0);
    ch_en = 8'h07; step();

    // Timeout with no ser_done, then a busy stall before the next channel
    ser_auto = 0;
    upd_req = 8'h03;
    upd_data[0*DATA_W +: DATA_W] = 16'h3030;
    upd_data[1*DATA_W +: DATA_W] = 16'h3131;
    step();
    clear_log();
    frame_start = 1; step();
    wait_log(1, 10);
    t0 = log_cyc[0];
    k = 0;
    while (!timeout_err && k < 200) begin step(); k++; end
    check_eq("tmo_seen", timeout_err, 1'b1);
    check_eq("tmo_cycles", cyc - t0, TIMEOUT);
    force_busy = 1; ser_busy = 1;
    n0 = log_ch.size();
    repeat (6) step();
    check_eq("busy_stall", log_ch.size(), n0);
    force_busy = 0; ser_busy = 0;
    step();
    check_eq("after_stall_cnt", log_ch.size(), n0 + 1);
    check_eq("after_stall_ch", log_ch[n0], 1);
    check_eq("after_stall_d", log_data[n0], 16'h3131);
    run_idle("tmo_end", 200);
    err_clr = 1; step();
    check_eq("tmo_clr", timeout_err, 1'b0);
    ser_auto = 1;

    // Asynchronous reset in WAIT
    write_ch(0, 16'h4444);
    clear_log();
    frame_start = 1; step();
    wait_log(1, 10);
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ser_start", ser_start, 1'b0);
    check_eq("rst_ser_ch", ser_ch, 3'd0);
    check_eq("rst_ser_data", ser_data, 16'h0000);
    check_eq("rst_pending", pending, 8'h00);
    check_eq("rst_frame_active", frame_active, 1'b0);
    check_eq("rst_flags", {overrun, timeout_err}, 2'b00);
    do_reset();
    clear_log();
    frame_start = 1; step();
    check_eq("empty_frame_scan", frame_active, 1'b1);
    step();
    check_eq("empty_frame_idle", frame_active, 1'b0);
    step();
    check_eq("empty_frame_nostart", log_ch.size(), 0);

    // Randomized traffic
    ch_en = 8'hFF;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 59) == 0) ch_en = ch_en ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) ch_en = 8'hFF;
      for (int j = 0; j < int'(NUM_CH); j++) upd_req[j] = ($urandom_range(0, 9) == 0);
      for (int j = 0; j < int'(NUM_CH); j++) upd_data[j*DATA_W +: DATA_W] = DATA_W'($urandom);
      frame_start = ($urandom_range(0, 14) == 0);
      err_clr     = ($urandom_range(0, 39) == 0);
      if (ser_cnt == 0 && $urandom_range(0, 39) == 0) ser_done = 1'b1;
      force_busy = ($urandom_range(0, 7) == 0);
      ser_busy = force_busy || (ser_cnt > 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
